// File: rtl/serdes_tx_serializer.sv
// Transmit serializer: sends a sync pattern and then a payload word, MSB first, one bit per enabled clock.
// Defining SERTX_PARITY_EN appends an even-parity bit to each frame.
module serdes_tx_serializer #(
    parameter int                DATA_W       = 8,
    parameter int                SYNC_W       = 8,
    parameter logic [SYNC_W-1:0] SYNC_PATTERN = 8'hA5,
    parameter logic              IDLE_LEVEL   = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              ser_out,
    output logic              busy,
    output logic              frame_start
);

    localparam int FRAME_W = SYNC_W + DATA_W;
    localparam int MAX_W   = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
    localparam int CNT_W   = $clog2(MAX_W + 1);
    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SYNC,
`ifdef SERTX_PARITY_EN
        ST_PARITY,
`endif
        ST_DATA
    } state_t;

    // state_reg and cnt_reg describe the bit currently on ser_out.
    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [FRAME_W-1:0] shift_reg, shift_next;
    logic               ser_out_reg, ser_out_next;
    logic               busy_reg, busy_next;
    logic               frame_start_reg, frame_start_next;
`ifdef SERTX_PARITY_EN
    logic               parity_reg, parity_next;
`endif

    logic final_bit;
    logic accept;

`ifdef SERTX_PARITY_EN
    assign final_bit = (state_reg == ST_PARITY);
`else
    assign final_bit = (state_reg == ST_DATA) && (cnt_reg == DATA_LAST);
`endif

    assign tx_ready    = ena & rst_n & ((state_reg == ST_IDLE) | final_bit);
    assign accept      = tx_valid & tx_ready;
    assign ser_out     = ser_out_reg;
    assign busy        = busy_reg;
    assign frame_start = frame_start_reg & ena;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            cnt_reg         <= '0;
            shift_reg       <= '0;
            ser_out_reg     <= IDLE_LEVEL;
            busy_reg        <= 1'b0;
            frame_start_reg <= 1'b0;
`ifdef SERTX_PARITY_EN
            parity_reg      <= 1'b0;
`endif
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            shift_reg       <= shift_next;
            ser_out_reg     <= ser_out_next;
            busy_reg        <= busy_next;
            frame_start_reg <= frame_start_next;
`ifdef SERTX_PARITY_EN
            parity_reg      <= parity_next;
`endif
        end
    end

    always_comb begin
        state_next       = state_reg;
        cnt_next         = cnt_reg;
        shift_next       = shift_reg;
        ser_out_next     = ser_out_reg;
        busy_next        = busy_reg;
        frame_start_next = 1'b0;
`ifdef SERTX_PARITY_EN
        parity_next      = parity_reg;
`endif

        if (ena) begin
            case (state_reg)
                ST_IDLE: begin
                    ser_out_next = IDLE_LEVEL;
                    busy_next    = 1'b0;
                end
                ST_SYNC: begin
                    // shift_reg holds the bits still to be sent, next one at the MSB.
                    ser_out_next = shift_reg[FRAME_W-1];
                    shift_next   = shift_reg << 1;
                    if (cnt_reg == SYNC_LAST) begin
                        state_next = ST_DATA;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (cnt_reg == DATA_LAST) begin
                        cnt_next = '0;
`ifdef SERTX_PARITY_EN
                        state_next   = ST_PARITY;
                        ser_out_next = parity_reg;
`else
                        state_next   = ST_IDLE;
                        ser_out_next = IDLE_LEVEL;
                        busy_next    = 1'b0;
`endif
                    end else begin
                        ser_out_next = shift_reg[FRAME_W-1];
                        shift_next   = shift_reg << 1;
                        cnt_next     = cnt_reg + 1'b1;
                    end
                end
`ifdef SERTX_PARITY_EN
                ST_PARITY: begin
                    state_next   = ST_IDLE;
                    ser_out_next = IDLE_LEVEL;
                    busy_next    = 1'b0;
                end
`endif
                default: begin
                    state_next   = ST_IDLE;
                    cnt_next     = '0;
                    ser_out_next = IDLE_LEVEL;
                    busy_next    = 1'b0;
                end
            endcase

            // A new frame overrides the idle/return path so back-to-back frames have no gap.
            if (accept) begin
                state_next       = ST_SYNC;
                cnt_next         = '0;
                shift_next       = {SYNC_PATTERN, tx_data} << 1;
                ser_out_next     = SYNC_PATTERN[SYNC_W-1];
                busy_next        = 1'b1;
                frame_start_next = 1'b1;
`ifdef SERTX_PARITY_EN
                parity_next      = ^tx_data;
`endif
            end
        end
    end

endmodule

// File: tb/tb_serdes_tx_serializer.sv
// Directed bench for serdes_tx_serializer; honours SERTX_PARITY_EN for the frame length.
module tb_serdes_tx_serializer;

`ifdef SERTX_PARITY_EN
    localparam int FL = 17;
`else
    localparam int FL = 16;
`endif

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       ser_out;
    logic       busy;
    logic       frame_start;

    int n_checks = 0;
    int n_fail   = 0;

    serdes_tx_serializer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .ser_out     (ser_out),
        .busy        (busy),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected bit i of a frame: sync 0xA5, then payload, then even parity.
    function automatic logic exp_bit(input logic [7:0] d, input int i);
        logic [15:0] f;
        f = {8'hA5, d};
        if (i < 16) return f[15-i];
        return ^d;
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input int stall_at);
        tx_valid = 1'b1;
        tx_data  = d;
        chk("ready_before_accept", tx_ready, 1'b1);
        tick();
        tx_valid = 1'b0;
        tx_data  = 8'hFF;
        for (int i = 0; i < FL; i++) begin
            chk($sformatf("bit%0d", i), ser_out, exp_bit(d, i));
            chk($sformatf("busy%0d", i), busy, 1'b1);
            chk($sformatf("fstart%0d", i), frame_start, i == 0);
            chk($sformatf("ready%0d", i), tx_ready, i == FL - 1);
            if (i == stall_at) begin
                ena = 1'b0;
                #1;
                chk("stall_ready", tx_ready, 1'b0);
                for (int s = 0; s < 3; s++) begin
                    tick();
                    chk($sformatf("stall_bit%0d", s), ser_out, exp_bit(d, i));
                    chk($sformatf("stall_busy%0d", s), busy, 1'b1);
                    chk($sformatf("stall_fstart%0d", s), frame_start, 1'b0);
                    chk($sformatf("stall_ready%0d", s), tx_ready, 1'b0);
                end
                ena = 1'b1;
            end
            tick();
        end
        chk("post_frame_ser", ser_out, 1'b0);
        chk("post_frame_busy", busy, 1'b0);
        $display("frame 0x%02h stall_at=%0d done", d, stall_at);
    endtask

    initial begin
        rst_n    = 1'b0;
        ena      = 1'b1;
        tx_valid = 1'b1;
        tx_data  = 8'h3C;
        #3;
        chk("rst_ser", ser_out, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ready", tx_ready, 1'b0);
        chk("rst_fstart", frame_start, 1'b0);
        tick();
        tx_valid = 1'b0;
        #2 rst_n = 1'b1;

        for (int c = 0; c < 20; c++) begin
            tick();
            chk("idle_ser", ser_out, 1'b0);
            chk("idle_busy", busy, 1'b0);
            chk("idle_ready", tx_ready, 1'b1);
            chk("idle_fstart", frame_start, 1'b0);
        end
        $display("idle 20 cycles done");

        send_frame(8'h3C, -1);
        send_frame(8'h07, -1);

        // Back-to-back: valid held high, data changes during frame 1 must be ignored.
        tx_valid = 1'b1;
        tx_data  = 8'h3C;
        chk("b2b_ready0", tx_ready, 1'b1);
        tick();
        for (int i = 0; i < 2 * FL; i++) begin
            if (i < FL - 1)  tx_data = 8'hFF;
            if (i == FL - 1) tx_data = 8'hC3;
            if (i == FL)     tx_valid = 1'b0;
            #1;
            chk($sformatf("b2b_bit%0d", i), ser_out,
                (i < FL) ? exp_bit(8'h3C, i) : exp_bit(8'hC3, i - FL));
            chk($sformatf("b2b_busy%0d", i), busy, 1'b1);
            chk($sformatf("b2b_fstart%0d", i), frame_start, (i == 0) || (i == FL));
            chk($sformatf("b2b_ready%0d", i), tx_ready, (i == FL - 1) || (i == 2 * FL - 1));
            tick();
        end
        chk("b2b_end_ser", ser_out, 1'b0);
        chk("b2b_end_busy", busy, 1'b0);
        $display("back-to-back 0x3C,0xC3 done");

        send_frame(8'h3C, 9);

        // Asynchronous reset in the middle of a frame.
        tx_valid = 1'b1;
        tx_data  = 8'h3C;
        tick();
        tx_valid = 1'b0;
        repeat (4) tick();
        chk("pre_abort_busy", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_ser", ser_out, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_ready", tx_ready, 1'b0);
        chk("abort_fstart", frame_start, 1'b0);
        tick();
        #2 rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("after_abort_ser", ser_out, 1'b0);
            chk("after_abort_busy", busy, 1'b0);
        end
        $display("mid-frame reset done");

        send_frame(8'h81, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
